// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM state encoding and the default timeout length.
package lsu_pkg;

   localparam int TIMEOUT_CYC_DEFAULT = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_timer.sv
// Saturating cycle counter that bounds how long one access may spend in REQ+WAIT.
// expired is raised in the last allowed cycle so the FSM leaves after exactly TIMEOUT_CYC cycles.
module lsu_timer
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && count != LIMIT) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count >= LAST);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one memory access per lw/sw, stalling the pipeline until it retires.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned addresses instead of word-aligning them.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              fault,
   output logic              mem_req_valid,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [31:0]       mem_req_wdata,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   input  logic [31:0]       mem_resp_rdata
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   lsu_state_t        state;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              we_q;
   logic              misalign;
   logic              start;
   logic              expired;

`ifdef LSU_MISALIGN_CHECK_EN
   assign misalign = |addr[1:0];
`else
   assign misalign = 1'b0;
`endif

   assign start = (state == IDLE) && (mem_read ^ mem_write) && !misalign;

   lsu_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (start),
      .enable  ((state == REQ) || (state == WAIT)),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata   <= '0;
         fault   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               fault <= 1'b0;
               if (mem_read && mem_write) begin
                  state <= DONE;
                  fault <= 1'b1;
               end else if (mem_read || mem_write) begin
                  if (misalign) begin
                     state <= DONE;
                     fault <= 1'b1;
                  end else begin
                     state   <= REQ;
                     addr_q  <= addr;
                     wdata_q <= wdata;
                     we_q    <= mem_write;
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  state <= WAIT;
               end else if (expired) begin
                  state <= DONE;
                  fault <= 1'b1;
               end
            end
            WAIT: begin
               // A successful response wins over a timeout landing in the same cycle.
               if (mem_resp_valid) begin
                  state <= DONE;
                  if (!we_q) begin
                     rdata <= mem_resp_rdata;
                  end
               end else if (expired) begin
                  state <= DONE;
                  fault <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               fault <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign done          = (state == DONE);
   assign mem_req_valid = (state == REQ);
   assign mem_req_we    = we_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_addr  = addr_q & ALIGN_MASK;
   assign stall         = ((state == IDLE) && (mem_read || mem_write))
                        || (state == REQ) || (state == WAIT);

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, SHALL be the cycles in REQ+WAIT before a timeout fault.
REQ-002 Parameter ADDR_W, default 32, SHALL be the address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset (asserted at 0).
REQ-005 mem_read  input  1  SHALL mean the current instruction is a load (lw).
REQ-006 mem_write  input  1  SHALL mean the current instruction is a store (sw).
REQ-007 addr  input  ADDR_W  SHALL be the effective address from the ALU result.
REQ-008 wdata  input  32  SHALL be the store data (rs2 value).
REQ-009 stall  output  1  SHALL hold PC and register-file write while high.
REQ-010 done  output  1  SHALL pulse high for one cycle when an access retires.
REQ-011 rdata  output  32  SHALL carry the last loaded word.
REQ-012 fault  output  1  SHALL be high with done when the access failed.
REQ-013 mem_req_valid/mem_req_we  output  1 each  SHALL be the memory request and its write flag.
REQ-014 mem_req_addr  output  ADDR_W; mem_req_wdata  output  32  SHALL be the request address and data.
REQ-015 mem_req_ready  input  1  SHALL mean memory accepts the request this cycle.
REQ-016 mem_resp_valid  input  1; mem_resp_rdata  input  32  SHALL be the response/ack and read data.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-018 IDLE with exactly one of mem_read/mem_write high SHALL capture addr, wdata and we into registers and go to REQ.
REQ-019 IDLE with both mem_read and mem_write high SHALL go to DONE with fault set, issuing no request.
REQ-020 stall SHALL be combinational: high in IDLE when an access is requested, high in REQ and WAIT, low in DONE.
REQ-021 REQ SHALL drive mem_req_valid=1 and hold addr/we/wdata stable until mem_req_ready=1, then go to WAIT.
REQ-022 WAIT SHALL sample mem_resp_valid only in WAIT; on 1, a load latches mem_resp_rdata into rdata, and a store treats it as ack; then go to DONE.
REQ-023 DONE SHALL assert done for one cycle, then return to IDLE unconditionally.
REQ-024 Minimum latency SHALL be 3 stall cycles (IDLE, REQ, WAIT) with done in the 4th cycle when ready and resp each arrive in their first cycle.
REQ-025 A cycle counter SHALL clear on entering REQ and increment in REQ/WAIT; at TIMEOUT_CYC the unit goes to DONE with fault=1, drops mem_req_valid and leaves rdata unchanged.
REQ-026 A response arriving outside WAIT SHALL be ignored.
REQ-027 rdata SHALL change only on a successful load and otherwise hold its value; a store SHALL never modify it.
REQ-028 The counter SHALL saturate, never wrap, and be at least clog2(TIMEOUT_CYC+1) bits wide.

Reset
REQ-029 reset low SHALL immediately force IDLE, drop mem_req_valid, and zero the counter, rdata, done, fault and captured registers, including mid-REQ/WAIT.
REQ-030 A memory response arriving after reset releases SHALL be ignored per REQ-026.

Configuration
REQ-031 With LSU_MISALIGN_CHECK_EN defined, addr[1:0]!=0 in IDLE SHALL go straight to DONE with fault=1 and no memory request.
REQ-032 Without LSU_MISALIGN_CHECK_EN, addr[1:0] SHALL be forced to 0 on mem_req_addr and no misalignment fault SHALL exist.

Structure
REQ-033 Package lsu_pkg SHALL hold the state typedef (IDLE/REQ/WAIT/DONE encodings) and the TIMEOUT_CYC default constant.
REQ-034 The timeout counter SHALL be one sub-module, lsu_timer (clear, enable, expired).

Verification
REQ-035 Load at 0x0000_0010, ready and resp immediate, resp_rdata=0xDEAD_BEEF -> stall high 3 cycles, done in cycle 4, rdata=0xDEAD_BEEF, fault=0.
REQ-036 Store 0x1234_5678 to 0x20, ready delayed 5 cycles -> mem_req_addr/wdata stable all 5 cycles, rdata unchanged, done after ack.
REQ-037 Load with no resp for 64 cycles -> done with fault=1, mem_req_valid low, rdata holds its prior value.
REQ-038 reset low during WAIT, then resp_valid=1 after release -> state IDLE, rdata=0, no done pulse.
REQ-039 mem_read=mem_write=1 -> no mem_req_valid, done+fault in the next cycle.
REQ-040 Load at 0x0000_0013 -> fault without request (macro defined), or request at 0x0000_0010 (macro undefined).
